gerador_direcao: RTL and testbench

Initiator side of the direction-command interface consumed by the player movement block. Converts four raw board buttons (north, south, east/leste, west/oeste) into debounced, mutually exclusive, single-cycle direction pulses N/S/L/O, with keyboard-style auto-repeat while a button is held. Outputs connect directly to the N/S/L/O inputs of the movement block, which treats any non-one-hot input as no-move.

---
 rtl/gerador_direcao_if.sv | 14 +
 rtl/gerador_direcao.sv | 84 ++++++++
 tb/tb_gerador_direcao.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gerador_direcao_if.sv
// gerador_direcao_if: raw board buttons in, one-hot direction pulses and debounced state out
interface gerador_direcao_if;
    logic       btn_n;
    logic       btn_s;
    logic       btn_l;
    logic       btn_o;
    logic       N;
    logic       S;
    logic       L;
    logic       O;
    logic [3:0] pressionado;
    modport master (input btn_n, btn_s, btn_l, btn_o, output N, S, L, O, pressionado);
    modport slave (output btn_n, btn_s, btn_l, btn_o, input N, S, L, O, pressionado);
endinterface

// File: rtl/gerador_direcao.sv
// gerador_direcao: debounced buttons to single-cycle one-hot direction pulses with auto-repeat
module gerador_direcao #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic               clk_50,
    input logic               reset,
    gerador_direcao_if.master bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LOAD = (REPEAT_DELAY == 0) ? '0 : TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state;
    logic [3:0]    raw;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    stable;
    logic [3:0]    dir;
    logic [3:0]    cur;
    logic [3:0]    pulse;
    logic [CW-1:0] cnt [4];
    logic [TW-1:0] timer;

    assign raw = {bus.btn_n, bus.btn_s, bus.btn_l, bus.btn_o};
    assign dir = ((stable & (stable - 4'd1)) == 4'd0) ? stable : 4'd0;
    assign {bus.N, bus.S, bus.L, bus.O} = pulse;
    assign bus.pressionado = stable;

    // two-flop synchronizer, then a per-button counter that flips stable after a long enough disagreement
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // first pulse on a new direction, then one after the delay and periodically while held
    always_ff @(posedge clk_50) begin
        if (!reset) begin
            state <= IDLE;
            cur <= '0;
            timer <= '0;
            pulse <= '0;
        end else begin
            pulse <= '0;
            if (dir == 4'd0) begin
                state <= IDLE;
            end else if (state == IDLE || dir != cur) begin
                pulse <= dir;
                cur <= dir;
                timer <= DELAY_LOAD;
                state <= DELAY;
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
            end else if (REPEAT_DELAY != 0) begin
                pulse <= cur;
                timer <= PERIOD_LOAD;
                state <= REPEAT;
            end
        end
    end
endmodule

// File: tb/tb_gerador_direcao.sv
// tb_gerador_direcao: directed button scenarios with a pulse scoreboard keyed by clock edge
module tb_gerador_direcao;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int LAT = DB + 2;

    typedef struct {
        int         t;
        logic [3:0] v;
    } exp_t;

    logic clk_50 = 0;
    logic reset = 0;
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;
    int   k;
    int   p;
    int   j;
    int   cnt0 = 0;
    int   first0_t = -1;
    logic [3:0] first0_v = '0;
    exp_t exp_q[$];

    gerador_direcao_if bus();
    gerador_direcao_if bus0();

    gerador_direcao #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk_50(clk_50),
        .reset(reset),
        .bus(bus)
    );

    gerador_direcao #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut0 (
        .clk_50(clk_50),
        .reset(reset),
        .bus(bus0)
    );

    always #10 clk_50 = ~clk_50;

    // edge index of the most recent rising clock edge
    always @(posedge clk_50) edge_n <= edge_n + 1;

    // scoreboard monitor: every pulse must match the next expected edge and direction
    always @(negedge clk_50) begin : mon
        exp_t e;
        logic [3:0] got;
        got = {bus.N, bus.S, bus.L, bus.O};
        if (got != 4'd0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected: got %b at edge %0d, expected none", got, edge_n);
            end else begin
                e = exp_q.pop_front();
                if (e.t != edge_n || e.v != got) begin
                    bad++;
                    $display("FAIL pulse: got %b at edge %0d, expected %b at edge %0d", got, edge_n, e.v, e.t);
                end
            end
        end
    end

    // pulse counter for the no-repeat instance
    always @(negedge clk_50) begin
        if ({bus0.N, bus0.S, bus0.L, bus0.O} != 4'd0) begin
            cnt0++;
            if (first0_t < 0) begin
                first0_t = edge_n;
                first0_v = {bus0.N, bus0.S, bus0.L, bus0.O};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clk_50);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, want, edge_n);
        end
    endtask

    task automatic push_train(input int first, input int last, input logic [3:0] v);
        exp_t x;
        int t;
        int gap;
        t = first;
        gap = RD;
        while (t <= last) begin
            x.t = t;
            x.v = v;
            exp_q.push_back(x);
            t += gap;
            gap = RP;
        end
    endtask

    initial begin
        {bus.btn_n, bus.btn_s, bus.btn_l, bus.btn_o} = '0;
        {bus0.btn_n, bus0.btn_s, bus0.btn_l, bus0.btn_o} = '0;
        wait_edge(3);
        chk("rst_dir", {bus.N, bus.S, bus.L, bus.O}, 0);
        chk("rst_press", bus.pressionado, 0);
        chk("rst_dir0", {bus0.N, bus0.S, bus0.L, bus0.O}, 0);
        reset = 1;
        wait_edge(6);
        // north held then released: first pulse, delayed repeat, periodic repeats until stable falls
        k = edge_n + 1;
        push_train(k + LAT, k + 31 + DB + 1, 4'b1000);
        bus.btn_n = 1;
        wait_edge(k + DB);
        chk("n_press_before", bus.pressionado, 0);
        wait_edge(k + DB + 1);
        chk("n_press_rise", bus.pressionado, 4'b1000);
        wait_edge(k + 30);
        bus.btn_n = 0;
        wait_edge(k + 35);
        chk("n_press_hold", bus.pressionado, 4'b1000);
        wait_edge(k + 36);
        chk("n_press_fall", bus.pressionado, 0);
        wait_edge(k + 50);
        // east bounce shorter than the debounce window never settles
        k = edge_n + 1;
        bus.btn_l = 1;
        wait_edge(k + 2);
        bus.btn_l = 0;
        wait_edge(k + 4);
        bus.btn_l = 1;
        wait_edge(k + 7);
        bus.btn_l = 0;
        for (int t = k + 8; t <= k + 20; t += 4) begin
            wait_edge(t);
            chk("bounce_press", bus.pressionado, 0);
        end
        // south+west together give no direction; releasing west starts south
        k = edge_n + 1;
        bus.btn_s = 1;
        bus.btn_o = 1;
        wait_edge(k + DB + 1);
        chk("so_press", bus.pressionado, 4'b0101);
        wait_edge(k + 20);
        chk("so_press_hold", bus.pressionado, 4'b0101);
        j = edge_n + 1;
        push_train(j + LAT, j + 30 + DB + 1, 4'b0100);
        bus.btn_o = 0;
        wait_edge(j + DB + 1);
        chk("s_press", bus.pressionado, 4'b0100);
        wait_edge(j + 29);
        bus.btn_s = 0;
        wait_edge(j + 50);
        // north into repeat, east added, north released: east becomes a fresh press
        k = edge_n + 1;
        push_train(k + LAT, k + 20 + DB + 1, 4'b1000);
        push_train(k + 22 + DB + 2, k + 40 + DB + 1, 4'b0010);
        bus.btn_n = 1;
        wait_edge(k + 19);
        bus.btn_l = 1;
        wait_edge(k + 21);
        bus.btn_n = 0;
        wait_edge(k + 25);
        chk("nl_press", bus.pressionado, 4'b1010);
        wait_edge(k + 27);
        chk("l_press", bus.pressionado, 4'b0010);
        wait_edge(k + 39);
        bus.btn_l = 0;
        wait_edge(k + 60);
        // west held through a two-cycle reset in the repeat phase
        k = edge_n + 1;
        push_train(k + LAT, k + 20, 4'b0001);
        bus.btn_o = 1;
        wait_edge(k + 20);
        reset = 0;
        wait_edge(k + 21);
        chk("rst_hold_dir", {bus.N, bus.S, bus.L, bus.O}, 0);
        chk("rst_hold_press", bus.pressionado, 0);
        wait_edge(k + 22);
        chk("rst_hold_dir2", {bus.N, bus.S, bus.L, bus.O}, 0);
        reset = 1;
        p = k + 23;
        push_train(p + LAT, k + 41 + DB + 1, 4'b0001);
        wait_edge(p);
        chk("post_rst_dir", {bus.N, bus.S, bus.L, bus.O}, 0);
        wait_edge(p + DB);
        chk("post_rst_press", bus.pressionado, 0);
        wait_edge(p + DB + 1);
        chk("post_rst_press_rise", bus.pressionado, 4'b0001);
        wait_edge(k + 40);
        bus.btn_o = 0;
        wait_edge(k + 60);
        // no-repeat instance: one pulse for a long hold
        k = edge_n + 1;
        bus0.btn_n = 1;
        wait_edge(k + DB + 1);
        chk("norep_press", bus0.pressionado, 4'b1000);
        wait_edge(k + 39);
        bus0.btn_n = 0;
        wait_edge(k + 60);
        chk("norep_count", cnt0, 1);
        chk("norep_edge", first0_t, k + LAT);
        chk("norep_dir", first0_v, 4'b1000);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
